// File: rtl/tile_pixel_gather.sv
// Gathers pixels for each accepted (i, j, lane) coordinate from image memory and
// packs them into per-beat lane vectors for the convolution engine.
module tile_pixel_gather #(
  parameter int IMG_LOG2  = 6,
  parameter int PIX_W     = 8,
  parameter int MAX_LANES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [6:0]                   num,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [6:0]                   in_i,
  input  logic [6:0]                   in_j,
  input  logic [6:0]                   in_lane,
  input  logic                         in_block_change,
  input  logic                         in_finish,
  output logic                         mem_rd,
  output logic [2*IMG_LOG2-1:0]        mem_addr,
  input  logic [PIX_W-1:0]             mem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MAX_LANES*PIX_W-1:0]   out_data,
  output logic [MAX_LANES-1:0]         out_mask,
  output logic                         out_blk_start,
  output logic                         out_done,
  output logic                         err_lane,
  output logic                         err_range
);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t state, state_n;

  logic [6:0] eff_l;
  logic       accept;
  logic       in_range_bad, in_lane_ok, in_last;

  logic       pend_valid, pend_last, pend_lane_ok, pend_bad, pend_blk, pend_fin;
  logic [6:0] pend_lane;

  logic [MAX_LANES*PIX_W-1:0] gather_data, merged_data;
  logic [MAX_LANES-1:0]       gather_mask, merged_mask;
  logic                       gather_blk, merged_blk;
  logic [PIX_W-1:0]           wr_pix;
  logic                       beat_done;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eff_l = num;
    if (num == 7'd0)
      eff_l = 7'd1;
    else if (num > 7'(MAX_LANES))
      eff_l = 7'(MAX_LANES);
  end

  assign in_ready = !rst && (state == RUN) && !(out_valid && !out_ready)
                    && !(pend_valid && pend_last);
  assign accept   = in_valid && in_ready;
  assign mem_rd   = accept;
  assign mem_addr = accept ? {in_j[IMG_LOG2-1:0], in_i[IMG_LOG2-1:0]} : '0;

  assign in_range_bad = ((in_i >> IMG_LOG2) != 7'd0) || ((in_j >> IMG_LOG2) != 7'd0);
  assign in_lane_ok   = in_lane < eff_l;
  // A lane outside the active set never closes a beat, even if it carries finish.
  assign in_last      = in_lane_ok && ((in_lane == eff_l - 7'd1) || in_finish);

  // NOTE: sequential state uses non-blocking assignments and the async reset branch first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid   <= 1'b0;
      pend_last    <= 1'b0;
      pend_lane_ok <= 1'b0;
      pend_bad     <= 1'b0;
      pend_blk     <= 1'b0;
      pend_fin     <= 1'b0;
      pend_lane    <= '0;
    end else begin
      pend_valid <= accept;
      if (accept) begin
        pend_last    <= in_last;
        pend_lane_ok <= in_lane_ok;
        pend_bad     <= in_range_bad;
        pend_blk     <= in_block_change;
        pend_fin     <= in_finish;
        pend_lane    <= in_lane;
      end
    end
  end

  assign wr_pix    = pend_bad ? '0 : mem_rdata;
  assign beat_done = pend_valid && pend_last;

  always_comb begin
    merged_data = gather_data;
    merged_mask = gather_mask;
    merged_blk  = gather_blk;
    if (pend_valid && pend_lane_ok) begin
      for (int k = 0; k < MAX_LANES; k++) begin
        if (pend_lane == 7'(k)) begin
          merged_data[k*PIX_W +: PIX_W] = wr_pix;
          merged_mask[k]                = 1'b1;
        end
      end
      if (pend_lane == 7'd0 && pend_blk)
        merged_blk = 1'b1;
    end
  end

  // NOTE: the gather buffer is plain flops, so it is reset; a completed beat empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gather_data <= '0;
      gather_mask <= '0;
      gather_blk  <= 1'b0;
    end else if (beat_done) begin
      gather_data <= '0;
      gather_mask <= '0;
      gather_blk  <= 1'b0;
    end else begin
      gather_data <= merged_data;
      gather_mask <= merged_mask;
      gather_blk  <= merged_blk;
    end
  end

  // in_ready guarantees a completing beat never lands on a stalled output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_mask      <= '0;
      out_blk_start <= 1'b0;
      out_done      <= 1'b0;
    end else if (beat_done) begin
      out_valid     <= 1'b1;
      out_data      <= merged_data;
      out_mask      <= merged_mask;
      out_blk_start <= merged_blk;
      out_done      <= pend_fin;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_lane  <= 1'b0;
      err_range <= 1'b0;
    end else if (pend_valid) begin
      if (!pend_lane_ok) err_lane  <= 1'b1;
      if (pend_bad)      err_range <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (accept && in_finish) state_n = FLUSH;
      FLUSH:   if (out_valid && out_ready && out_done) state_n = DONE;
      DONE:    state_n = DONE;
      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_tile_pixel_gather.sv
// Self-checking bench for tile_pixel_gather: directed scenarios plus randomized
// streams checked against a coordinate-level reference model.
module tb_tile_pixel_gather;

  localparam int IMG_LOG2  = 6;
  localparam int PIX_W     = 8;
  localparam int MAX_LANES = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  num = 7'd4;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_i = '0, in_j = '0, in_lane = '0;
  logic        in_block_change = 1'b0, in_finish = 1'b0;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [7:0]  out_mask;
  logic        out_blk_start, out_done, err_lane, err_range;

  always #5 clk = ~clk;

  tile_pixel_gather #(.IMG_LOG2(IMG_LOG2), .PIX_W(PIX_W), .MAX_LANES(MAX_LANES)) dut (
    .clk(clk), .rst(rst), .num(num),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_j(in_j), .in_lane(in_lane),
    .in_block_change(in_block_change), .in_finish(in_finish),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .out_blk_start(out_blk_start), .out_done(out_done),
    .err_lane(err_lane), .err_range(err_range)
  );

  // Image memory with one-cycle read latency; junk on the bus when not reading.
  logic [7:0] img [4096];
  always @(posedge clk) mem_rdata <= mem_rd ? img[mem_addr] : 8'($urandom);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-beat lane vectors built directly from accepted coordinates.
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  mask;
    logic        blk;
    logic        done;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] m_data;
  logic [7:0]  m_mask;
  logic        m_blk, m_err_lane, m_err_range;
  bit          rand_ready = 1'b0;

  function automatic int lanes_of(input int n);
    return (n == 0) ? 1 : ((n > MAX_LANES) ? MAX_LANES : n);
  endfunction

  task automatic model_reset();
    m_data = '0; m_mask = '0; m_blk = 1'b0;
    m_err_lane = 1'b0; m_err_range = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int i, input int j, input int lane, input bit blk, input bit fin);
    int         l;
    bit         bad;
    logic [7:0] pix;
    beat_t      b;
    l   = lanes_of(int'(num));
    bad = (i >= 64) || (j >= 64);
    pix = bad ? 8'd0 : img[(j % 64) * 64 + (i % 64)];
    if (bad) m_err_range = 1'b1;
    if (lane >= l) begin
      m_err_lane = 1'b1;
    end else begin
      m_data[lane*8 +: 8] = pix;
      m_mask[lane]        = 1'b1;
      if (lane == 0 && blk) m_blk = 1'b1;
      if (lane == l - 1 || fin) begin
        b.data = m_data; b.mask = m_mask; b.blk = m_blk; b.done = fin;
        exp_q.push_back(b);
        m_data = '0; m_mask = '0; m_blk = 1'b0;
      end
    end
  endtask

  // Scoreboard: every transferred beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", out_data, e.data);
        check("beat_mask", 64'(out_mask), 64'(e.mask));
        check("beat_blk_start", 64'(out_blk_start), 64'(e.blk));
        check("beat_done", 64'(out_done), 64'(e.done));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_mask", 64'(out_mask), 64'd0);
    check("rst_flags", 64'({out_blk_start, out_done, err_lane, err_range}), 64'd0);
  endtask

  // Asynchronous reset: outputs must clear without waiting for an edge.
  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    num = 7'(n);
    model_reset();
    #1;
    check_reset_outputs();
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();
  endtask

  task automatic send(input int i, input int j, input int lane, input bit blk, input bit fin);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_i = 7'(i); in_j = 7'(j); in_lane = 7'(lane);
    in_block_change = blk; in_finish = fin;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        check("mem_rd", 64'(mem_rd), 64'd1);
        check("mem_addr", 64'(mem_addr), 64'(((j % 64) * 64) + (i % 64)));
        model_accept(i, j, lane, blk, fin);
      end
      tick();
    end
    check("accepted", 64'(got), 64'd1);
    in_valid = 1'b0;
    in_block_change = 1'b0;
    in_finish = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !out_valid;
      if (!ok) tick();
    end
    check("drained", 64'(ok), 64'd1);
    tick();
  endtask

  task automatic check_errors();
    check("err_lane", 64'(err_lane), 64'(m_err_lane));
    check("err_range", 64'(err_range), 64'(m_err_range));
  endtask

  task automatic check_done_state();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("done_in_ready", 64'(in_ready), 64'd0);
      check("done_mem_rd", 64'(mem_rd), 64'd0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int l, lane, ln, ci, cj;
    bit blk;

    for (int a = 0; a < 4096; a++) img[a] = 8'(((a % 64) + 3 * (a / 64)) & 8'hFF);

    // Basic beat with latency and single bubble after the last lane.
    do_reset(4);
    out_ready = 1'b1;
    send(0, 0, 0, 1'b1, 1'b0);
    send(8, 0, 1, 1'b0, 1'b0);
    send(16, 0, 2, 1'b0, 1'b0);
    send(24, 0, 3, 1'b0, 1'b0);
    @(negedge clk);
    check("bubble_in_ready", 64'(in_ready), 64'd0);
    check("latency_not_yet", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("latency_valid", 64'(out_valid), 64'd1);
    check("first_beat_data", out_data, 64'h0000_0000_1810_0800);
    check("first_beat_mask", 64'(out_mask), 64'h0F);
    tick();
    drain();

    // Output stall: beat held stable, input blocked, no beat lost afterwards.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(k + 1, 2, k, k == 0, 1'b0);
    tick();
    in_valid = 1'b1; in_i = 7'd10; in_j = 7'd5; in_lane = 7'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", out_data, exp_q[0].data);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(10 + k, 5, k, 1'b0, 1'b0);
    drain();

    // Lane error: dropped pixel, sticky flag, beat still completes on lane 3.
    send(0, 1, 0, 1'b0, 1'b0);
    send(1, 1, 1, 1'b0, 1'b0);
    send(2, 1, 5, 1'b0, 1'b0);
    send(3, 1, 2, 1'b0, 1'b0);
    send(4, 1, 3, 1'b0, 1'b0);
    drain();
    check_errors();

    // Range error: read still issued, slot forced to zero.
    send(64, 3, 0, 1'b0, 1'b0);
    send(5, 3, 1, 1'b0, 1'b0);
    send(6, 3, 2, 1'b0, 1'b0);
    send(7, 3, 3, 1'b0, 1'b0);
    drain();
    check_errors();

    // Partial final beat on finish, then DONE until reset.
    do_reset(3);
    send(1, 2, 0, 1'b1, 1'b0);
    send(63, 63, 1, 1'b0, 1'b1);
    drain();
    check_done_state();

    // Reset with an output beat held, then with a read in flight.
    do_reset(4);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(20 + k, 7, k, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    tick();
    do_reset(4);
    out_ready = 1'b1;
    send(30, 9, 0, 1'b0, 1'b0);
    send(31, 9, 1, 1'b0, 1'b0);
    do_reset(4);
    for (int k = 0; k < 4; k++) send(40 + k, 11, k, 1'b1, 1'b0);
    drain();

    // Randomized streams across lane counts, including clamped num values.
    for (int cfg = 0; cfg < 8; cfg++) begin
      do_reset(cfg == 0 ? 0 : (cfg == 1 ? 12 : $urandom_range(1, 8)));
      l = lanes_of(int'(num));
      rand_ready = 1'b1;
      lane = 0;
      for (int s = 0; s < 40; s++) begin
        ci = $urandom_range(0, 63);
        cj = $urandom_range(0, 63);
        case ($urandom_range(0, 9))
          0: ci = 64 + $urandom_range(0, 63);
          1: cj = 64 + $urandom_range(0, 63);
          default: ;
        endcase
        if ($urandom_range(0, 9) == 0) begin
          ln = $urandom_range(l, l + 3);
        end else begin
          ln = lane;
          lane = (lane + 1) % l;
        end
        blk = (ln == 0) && ($urandom_range(0, 1) == 1);
        send(ci, cj, ln, blk, 1'b0);
      end
      send($urandom_range(0, 63), $urandom_range(0, 63), lane, 1'b0, 1'b1);
      drain();
      rand_ready = 1'b0;
      out_ready = 1'b1;
      check_errors();
      check_done_state();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
